// File: rtl/seg_memory_pkg.sv
// Shared definitions for the MIPS MEM stage: control-bus bit positions,
// access-size encodings, forwarding select codes and the alignment helper.
package seg_memory_pkg;

  localparam int LEN_DEF        = 32;
  localparam int NB_ADDR_DEF    = 5;
  localparam int NB_CTRL_WB_DEF = 2;
  localparam int NB_CTRL_M_DEF  = 9;
  localparam int RAM_DEPTH_DEF  = 256;

  localparam int MEM_READ_BIT  = 8;
  localparam int MEM_WRITE_BIT = 7;
  localparam int BRANCH_BIT    = 6;
  localparam int BRANCH_NE_BIT = 5;
  localparam int JUMP_BIT      = 4;
  localparam int SIZE_HI_BIT   = 3;
  localparam int SIZE_LO_BIT   = 2;
  localparam int UNSIGNED_BIT  = 1;

  localparam int REG_WRITE_BIT = 1;
  localparam int MEMTOREG_BIT  = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } mem_size_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // The reserved size code behaves as a word access.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/seg_memory_if.sv
// Execute-to-memory bus plus the MEM stage's forwarding, branch and MEM/WB outputs.
interface seg_memory_if
  import seg_memory_pkg::*;
#(
  parameter int LEN        = LEN_DEF,
  parameter int NB_ADDR    = NB_ADDR_DEF,
  parameter int NB_CTRL_WB = NB_CTRL_WB_DEF,
  parameter int NB_CTRL_M  = NB_CTRL_M_DEF
);
  logic [LEN-1:0]        i_ALU_result;
  logic [LEN-1:0]        i_write_data;
  logic [NB_ADDR-1:0]    i_write_register;
  logic                  i_ALU_zero;
  logic [LEN-1:0]        i_PC_branch;
  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus;

  logic [LEN-1:0]        o_rd_mem_forwarding;
  logic                  o_pc_src;
  logic [LEN-1:0]        o_PC_branch;
  logic [LEN-1:0]        o_read_data;
  logic [LEN-1:0]        o_ALU_result;
  logic [NB_ADDR-1:0]    o_write_register;
  logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus;
  logic                  o_misaligned;

  modport master (
    output i_ALU_result, i_write_data, i_write_register, i_ALU_zero,
           i_PC_branch, i_ctrl_wb_bus, i_ctrl_mem_bus,
    input  o_rd_mem_forwarding, o_pc_src, o_PC_branch, o_read_data,
           o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned
  );

  modport slave (
    input  i_ALU_result, i_write_data, i_write_register, i_ALU_zero,
           i_PC_branch, i_ctrl_wb_bus, i_ctrl_mem_bus,
    output o_rd_mem_forwarding, o_pc_src, o_PC_branch, o_read_data,
           o_ALU_result, o_write_register, o_ctrl_wb_bus, o_misaligned
  );

endinterface

// File: rtl/seg_memory_data_ram.sv
// Data memory: word array with per-byte write enables and async read.
// SEG_MEMORY_DEBUG_PORT_EN adds a second async read port for the debug unit.
module seg_memory_data_ram #(
  parameter int LEN       = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [LEN/8-1:0]             i_be,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_addr,
  input  logic [LEN-1:0]               i_wdata,
  output logic [LEN-1:0]               o_rdata
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  ,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_dbg_addr,
  output logic [LEN-1:0]               o_dbg_data
`endif
);

  logic [LEN-1:0] mem [RAM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < LEN/8; i++) begin
        if (i_be[i]) mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = mem[i_addr];

`ifdef SEG_MEMORY_DEBUG_PORT_EN
  assign o_dbg_data = mem[i_dbg_addr];
`endif

endmodule

// File: rtl/seg_memory.sv
// MIPS MEM stage: EX/MEM register, lane steering, load extension, branch decision, MEM/WB register.
// Define SEG_MEMORY_DEBUG_PORT_EN to expose the data memory debug read port.
module seg_memory
  import seg_memory_pkg::*;
#(
  parameter int LEN        = LEN_DEF,
  parameter int NB_ADDR    = NB_ADDR_DEF,
  parameter int NB_CTRL_WB = NB_CTRL_WB_DEF,
  parameter int NB_CTRL_M  = NB_CTRL_M_DEF,
  parameter int RAM_DEPTH  = RAM_DEPTH_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_halt,
  input  logic         i_flush,
  seg_memory_if.slave  bus
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  ,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_dbg_addr,
  output logic [LEN-1:0]               o_dbg_data
`endif
);

  localparam int NB_WIDX = $clog2(RAM_DEPTH);

  logic [LEN-1:0]        exm_alu;
  logic [LEN-1:0]        exm_wdata;
  logic [NB_ADDR-1:0]    exm_wreg;
  logic                  exm_zero;
  logic [NB_CTRL_WB-1:0] exm_ctrl_wb;
  logic [NB_CTRL_M-1:0]  exm_ctrl_m;

  always_ff @(posedge i_clk) begin
    if (!i_rst || (!i_halt && i_flush)) begin
      exm_alu     <= '0;
      exm_wdata   <= '0;
      exm_wreg    <= '0;
      exm_zero    <= 1'b0;
      exm_ctrl_wb <= '0;
      exm_ctrl_m  <= '0;
    end else if (!i_halt) begin
      exm_alu     <= bus.i_ALU_result;
      exm_wdata   <= bus.i_write_data;
      exm_wreg    <= bus.i_write_register;
      exm_zero    <= bus.i_ALU_zero;
      exm_ctrl_wb <= bus.i_ctrl_wb_bus;
      exm_ctrl_m  <= bus.i_ctrl_mem_bus;
    end
  end

  mem_size_e      size;
  logic [1:0]     lane;
  logic           mem_rd;
  logic           mem_wr;
  logic           misaligned;
  logic           ram_we;
  logic [3:0]     be;
  logic [LEN-1:0] wr_data;
  logic [LEN-1:0] rd_word;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [LEN-1:0] ld_data;
  logic           sign_fill;
  logic           ctrl_unused;

  assign size        = mem_size_e'(exm_ctrl_m[SIZE_HI_BIT:SIZE_LO_BIT]);
  assign lane        = exm_alu[1:0];
  assign mem_rd      = exm_ctrl_m[MEM_READ_BIT];
  assign mem_wr      = exm_ctrl_m[MEM_WRITE_BIT];
  assign misaligned  = (mem_rd | mem_wr) & is_misaligned(size, lane);
  assign ram_we      = mem_wr & ~misaligned & ~i_halt;
  assign ctrl_unused = exm_ctrl_m[0];

  // Narrow stores replicate the datum across the word; byte enables pick the lane.
  always_comb begin
    be      = 4'b0000;
    wr_data = exm_wdata;
    case (size)
      SZ_BYTE: begin
        be[lane] = 1'b1;
        wr_data  = {4{exm_wdata[7:0]}};
      end
      SZ_HALF: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{exm_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  seg_memory_data_ram #(
    .LEN       (LEN),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_data_ram (
    .i_clk      (i_clk),
    .i_we       (ram_we),
    .i_be       (be),
    .i_addr     (exm_alu[NB_WIDX+1:2]),
    .i_wdata    (wr_data),
    .o_rdata    (rd_word)
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    ,
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
`endif
  );

  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    sign_fill = 1'b0;
    ld_data   = rd_word;
    case (size)
      SZ_BYTE: begin
        sign_fill = ~exm_ctrl_m[UNSIGNED_BIT] & rd_byte[7];
        ld_data   = {{24{sign_fill}}, rd_byte};
      end
      SZ_HALF: begin
        sign_fill = ~exm_ctrl_m[UNSIGNED_BIT] & rd_half[15];
        ld_data   = {{16{sign_fill}}, rd_half};
      end
      default: ld_data = rd_word;
    endcase
    if (!mem_rd || misaligned) ld_data = '0;
  end

  assign bus.o_rd_mem_forwarding = exm_alu;
  assign bus.o_PC_branch         = bus.i_PC_branch;
  assign bus.o_pc_src = ~i_halt & (exm_ctrl_m[JUMP_BIT]
                                   | (exm_ctrl_m[BRANCH_BIT] & exm_zero)
                                   | (exm_ctrl_m[BRANCH_NE_BIT] & ~exm_zero));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      bus.o_read_data      <= '0;
      bus.o_ALU_result     <= '0;
      bus.o_write_register <= '0;
      bus.o_ctrl_wb_bus    <= '0;
      bus.o_misaligned     <= 1'b0;
    end else if (!i_halt) begin
      bus.o_read_data      <= ld_data;
      bus.o_ALU_result     <= exm_alu;
      bus.o_write_register <= exm_wreg;
      bus.o_ctrl_wb_bus    <= exm_ctrl_wb;
      bus.o_misaligned     <= misaligned;
    end
  end

endmodule

// File: tb/tb_seg_memory.sv
// Directed bench for seg_memory: expected MEM/WB rows are queued at issue and
// compared two clocks later; branch/forwarding outputs are checked at issue.
module tb_seg_memory;
  import seg_memory_pkg::*;

  logic i_clk  = 1'b0;
  logic i_rst  = 1'b0;
  logic i_halt = 1'b0;
  logic i_flush = 1'b0;

  always #5 i_clk = ~i_clk;

  seg_memory_if bus ();

`ifdef SEG_MEMORY_DEBUG_PORT_EN
  logic [7:0]  i_dbg_addr = 8'd0;
  logic [31:0] o_dbg_data;
`endif

  seg_memory dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_halt  (i_halt),
    .i_flush (i_flush),
    .bus     (bus)
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    ,
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
`endif
  );

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic        mis;
  } wb_row_t;

  wb_row_t exp_q[$];
  string   tag_q[$];
  wb_row_t last_row;
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [8:0] mctl(input logic rd, input logic wr, input logic br,
                                      input logic bne, input logic jmp,
                                      input logic [1:0] sz, input logic uns);
    mctl = {rd, wr, br, bne, jmp, sz, uns, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_row(input string tag, input wb_row_t e);
    chk({tag, ".rd"},   bus.o_read_data,                e.rd);
    chk({tag, ".alu"},  bus.o_ALU_result,               e.alu);
    chk({tag, ".wreg"}, {27'd0, bus.o_write_register},  {27'd0, e.wreg});
    chk({tag, ".wb"},   {30'd0, bus.o_ctrl_wb_bus},     {30'd0, e.wb});
    chk({tag, ".mis"},  {31'd0, bus.o_misaligned},      {31'd0, e.mis});
  endtask

  task automatic drive_junk();
    bus.i_ctrl_mem_bus   = mctl(1, 1, 1, 1, 1, SZ_WORD, 0);
    bus.i_ctrl_wb_bus    = 2'b11;
    bus.i_ALU_result     = 32'h0000_03FC;
    bus.i_write_data     = 32'hA5A5_A5A5;
    bus.i_write_register = 5'd31;
    bus.i_ALU_zero       = 1'b1;
    bus.i_PC_branch      = 32'hFFFF_0000;
  endtask

  task automatic step(input string tag, input logic [8:0] m, input logic [1:0] wb,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] wr,
                      input logic zero, input logic flush, input logic [31:0] exp_rd,
                      input logic exp_mis, input logic exp_pc);
    wb_row_t e;
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_halt  = 1'b0;
    i_flush = flush;
    bus.i_ctrl_mem_bus   = m;
    bus.i_ctrl_wb_bus    = wb;
    bus.i_ALU_result     = addr;
    bus.i_write_data     = wdata;
    bus.i_write_register = wr;
    bus.i_ALU_zero       = zero;
    bus.i_PC_branch      = 32'h1000 + addr;
    e = flush ? '0 : {exp_rd, addr, wr, wb, exp_mis};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge i_clk);
    #1;
    chk({tag, ".fwd"},  bus.o_rd_mem_forwarding, flush ? 32'd0 : addr);
    chk({tag, ".pcsrc"}, {31'd0, bus.o_pc_src}, {31'd0, exp_pc});
    chk({tag, ".pcbr"}, bus.o_PC_branch, 32'h1000 + addr);
    if (exp_q.size() > 1) begin
      last_row = exp_q.pop_front();
      check_row(tag_q.pop_front(), last_row);
    end
  endtask

  task automatic hold_step(input string tag, input logic [31:0] exp_fwd);
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_halt  = 1'b1;
    i_flush = 1'b1;
    drive_junk();
    @(posedge i_clk);
    #1;
    chk({tag, ".fwd"},   bus.o_rd_mem_forwarding, exp_fwd);
    chk({tag, ".pcsrc"}, {31'd0, bus.o_pc_src}, 32'd0);
    check_row(tag, last_row);
  endtask

  task automatic reset_step(input string tag);
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_halt  = 1'b1;
    i_flush = 1'b1;
    drive_junk();
    @(posedge i_clk);
    #1;
    chk({tag, ".fwd"},   bus.o_rd_mem_forwarding, 32'd0);
    chk({tag, ".pcsrc"}, {31'd0, bus.o_pc_src}, 32'd0);
    check_row(tag, '0);
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back('0);
    tag_q.push_back({tag, ".bubble"});
    last_row = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_junk();
    reset_step("rst0");
    reset_step("rst1");

    // Stores and extended loads around word 0x10
    step("sw_10",   mctl(0,1,0,0,0,SZ_WORD,0), 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, 0, 0);
    step("lb_13",   mctl(1,0,0,0,0,SZ_BYTE,0), 2'b11, 32'h13, 32'h0, 5'd3, 0, 0, 32'hFFFFFFDE, 0, 0);
    step("lbu_13",  mctl(1,0,0,0,0,SZ_BYTE,1), 2'b11, 32'h13, 32'h0, 5'd4, 0, 0, 32'h000000DE, 0, 0);
    step("lh_12",   mctl(1,0,0,0,0,SZ_HALF,0), 2'b11, 32'h12, 32'h0, 5'd5, 0, 0, 32'hFFFFDEAD, 0, 0);
    step("lhu_10",  mctl(1,0,0,0,0,SZ_HALF,1), 2'b11, 32'h10, 32'h0, 5'd6, 0, 0, 32'h0000BEEF, 0, 0);
    step("lb_11",   mctl(1,0,0,0,0,SZ_BYTE,0), 2'b11, 32'h11, 32'h0, 5'd7, 0, 0, 32'hFFFFFFBE, 0, 0);
    step("sb_11",   mctl(0,1,0,0,0,SZ_BYTE,0), 2'b00, 32'h11, 32'h0000005A, 5'd0, 0, 0, 32'h0, 0, 0);
    step("sh_12",   mctl(0,1,0,0,0,SZ_HALF,0), 2'b00, 32'h12, 32'h00007788, 5'd0, 0, 0, 32'h0, 0, 0);
    step("lw_10",   mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h10, 32'h0, 5'd8, 0, 0, 32'h77885AEF, 0, 0);

    // Misalignment, reserved size, read+write in the same access
    step("sw_20",    mctl(0,1,0,0,0,SZ_WORD,0), 2'b00, 32'h20, 32'hCAFEF00D, 5'd0, 0, 0, 32'h0, 0, 0);
    step("sh_21",    mctl(0,1,0,0,0,SZ_HALF,0), 2'b00, 32'h21, 32'h00001234, 5'd0, 0, 0, 32'h0, 1, 0);
    step("lw_20",    mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h20, 32'h0, 5'd9, 0, 0, 32'hCAFEF00D, 0, 0);
    step("lw_22",    mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h22, 32'h0, 5'd10, 0, 0, 32'h0, 1, 0);
    step("lsz10_20", mctl(1,0,0,0,0,SZ_RSVD,0), 2'b11, 32'h20, 32'h0, 5'd11, 0, 0, 32'hCAFEF00D, 0, 0);
    step("rw_20",    mctl(1,1,0,0,0,SZ_WORD,0), 2'b11, 32'h20, 32'h11112222, 5'd12, 0, 0, 32'hCAFEF00D, 0, 0);
    step("lw_20b",   mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h20, 32'h0, 5'd13, 0, 0, 32'h11112222, 0, 0);
    step("alu_op",   mctl(0,0,0,0,0,SZ_BYTE,0), 2'b10, 32'h20, 32'h0, 5'd14, 0, 0, 32'h0, 0, 0);

    // Branch resolution and flush
    step("beq_t",    mctl(0,0,1,0,0,SZ_BYTE,0), 2'b00, 32'h40, 32'h0, 5'd0, 1, 0, 32'h0, 0, 1);
    step("bne_z",    mctl(0,0,0,1,0,SZ_BYTE,0), 2'b00, 32'h44, 32'h0, 5'd0, 1, 0, 32'h0, 0, 0);
    step("bne_nz",   mctl(0,0,0,1,0,SZ_BYTE,0), 2'b00, 32'h48, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    step("jump",     mctl(0,0,0,0,1,SZ_BYTE,0), 2'b00, 32'h4C, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    step("beq_nt",   mctl(0,0,1,0,0,SZ_BYTE,0), 2'b00, 32'h50, 32'h0, 5'd0, 0, 0, 32'h0, 0, 0);
    step("flush_sw", mctl(0,1,1,0,0,SZ_WORD,0), 2'b10, 32'h20, 32'h99999999, 5'd15, 1, 1, 32'h0, 0, 0);
    step("lw_20c",   mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h20, 32'h0, 5'd16, 0, 0, 32'h11112222, 0, 0);

    // Reset mid-stream; RAM contents survive
    step("lw_pre",   mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h10, 32'h0, 5'd17, 0, 0, 32'h77885AEF, 0, 0);
    reset_step("rst_mid");
    step("lw_post",  mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h10, 32'h0, 5'd18, 0, 0, 32'h77885AEF, 0, 0);

    // Halt over a store carrying a jump
    step("sw_jmp_30", mctl(0,1,0,0,1,SZ_WORD,0), 2'b00, 32'h30, 32'h0BADF00D, 5'd0, 0, 0, 32'h0, 0, 1);
    hold_step("halt0", 32'h30);
    hold_step("halt1", 32'h30);
    hold_step("halt2", 32'h30);
    step("lw_30",    mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h30, 32'h0, 5'd19, 0, 0, 32'h0BADF00D, 0, 0);

    // Address wrap
    step("sw_400",   mctl(0,1,0,0,0,SZ_WORD,0), 2'b00, 32'h400, 32'h600DCAFE, 5'd0, 0, 0, 32'h0, 0, 0);
    step("lw_000",   mctl(1,0,0,0,0,SZ_WORD,0), 2'b11, 32'h0, 32'h0, 5'd20, 0, 0, 32'h600DCAFE, 0, 0);
`ifdef SEG_MEMORY_DEBUG_PORT_EN
    i_dbg_addr = 8'd0;
    #1;
    chk("dbg_idx0", o_dbg_data, 32'h600DCAFE);
`endif
    step("nop_drain", mctl(0,0,0,0,0,SZ_BYTE,0), 2'b00, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
